// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state/kind enums and widths for the memory arbiter
package mem_arb_pkg;
    import cpu_types_pkg::*;

    localparam int WORD_W   = $bits(word_t);
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} arb_state_t;
    typedef enum logic [1:0] {RK_IFETCH, RK_DREAD, RK_DWRITE} req_kind_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - datapath request and RAM access signals of the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Datapath and RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_streak.sv
// rtl/mem_arbiter_streak.sv - saturating count of data grants taken while a fetch waits
module arb_streak_counter #(
    parameter int MAX = 4,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);
    localparam logic [W-1:0] MAX_C = W'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && count != MAX_C) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == MAX_C);
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-ported RAM between instruction fetch and data port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = WORD_W,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    arb_state_t          state;
    arb_state_t          state_nx;
    req_kind_t           kind_q;
    logic [ADDR_W-1:2]   addr_q;
    logic [DATA_W-1:0]   store_q;
    logic [DATA_W-1:0]   iload_q;
    logic [DATA_W-1:0]   dload_q;
    logic                grant_d;
    logic                grant_i;
    logic                ihit;
    logic                dhit;
    logic                ren;
    logic                wen;
    logic                streak_sat;
    logic [STREAK_W-1:0] streak;

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        ren      = 1'b0;
        wen      = 1'b0;
        unique case (state)
            IDLE: begin
                // Data wins unless the waiting fetch has already yielded MAX_DSTREAK times
                if ((bus.dREN || bus.dWEN) && !(bus.iREN && streak_sat)) begin
                    grant_d  = 1'b1;
                    state_nx = DACC;
                end else if (bus.iREN) begin
                    grant_i  = 1'b1;
                    state_nx = IACC;
                end
            end
            IACC: begin
                ren  = 1'b1;
                ihit = bus.ramready;
                if (bus.ramready) state_nx = DONE;
            end
            DACC: begin
                ren  = (kind_q != RK_DWRITE);
                wen  = (kind_q == RK_DWRITE);
                dhit = bus.ramready;
                if (bus.ramready) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            kind_q  <= RK_IFETCH;
            addr_q  <= '0;
            store_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state <= state_nx;
            if (grant_d) begin
                kind_q  <= bus.dWEN ? RK_DWRITE : RK_DREAD;
                addr_q  <= bus.daddr[ADDR_W-1:2];
                store_q <= bus.dstore;
            end else if (grant_i) begin
                kind_q  <= RK_IFETCH;
                addr_q  <= bus.iaddr[ADDR_W-1:2];
            end
            if (ihit) iload_q <= bus.ramload;
            if (dhit && kind_q == RK_DREAD) dload_q <= bus.ramload;
        end
    end

    arb_streak_counter #(
        .MAX (MAX_DSTREAK),
        .W   (STREAK_W)
    ) u_streak (
        .clk   (CLK),
        .rst   (RST),
        .inc   (grant_d && bus.iREN),
        .clr   (grant_i || (grant_d && !bus.iREN)),
        .count (streak),
        .sat   (streak_sat)
    );

    // Loads are forwarded during the hit cycle so the hit and its data coincide
    assign bus.ihit     = ihit;
    assign bus.dhit     = dhit;
    assign bus.iload    = ihit ? bus.ramload : iload_q;
    assign bus.dload    = (dhit && kind_q == RK_DREAD) ? bus.ramload : dload_q;
    assign bus.ramREN   = ren;
    assign bus.ramWEN   = wen;
    assign bus.ramaddr  = (ren || wen) ? {addr_q, 2'b00} : '0;
    assign bus.ramstore = wen ? store_q : '0;
endmodule
